ssr_reply_decoder: RTL and testbench

SSR_REPLY_DECODER -- requirements
Module: ssr_reply_decoder

---
 rtl/ssr_reply_decoder_pkg.sv | 38 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/ssr_reply_decoder.sv | 116 +++++++++++
 tb/tb_ssr_reply_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssr_reply_decoder_pkg.sv
// Shared SSR definitions: reply timing, slot map and decoder state encoding.
// Slot n of a reply lands in shift-register bit (13 - n) once slots 1..13 are captured.
package ssr_reply_decoder_pkg;

  localparam int SSR_L     = 9;
  localparam int SSR_BL    = 20;
  localparam int SSR_PITCH = SSR_L + SSR_BL;

  localparam int SLOT_C1 = 1;
  localparam int SLOT_A1 = 2;
  localparam int SLOT_C2 = 3;
  localparam int SLOT_A2 = 4;
  localparam int SLOT_C4 = 5;
  localparam int SLOT_A4 = 6;
  localparam int SLOT_X  = 7;
  localparam int SLOT_B1 = 8;
  localparam int SLOT_D1 = 9;
  localparam int SLOT_B2 = 10;
  localparam int SLOT_D2 = 11;
  localparam int SLOT_B4 = 12;
  localparam int SLOT_D4 = 13;
  localparam int SLOT_F2 = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    F1_CHK = 2'd1,
    SLOT   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  function automatic logic [11:0] slots_to_code(input logic [12:0] sh);
    return {sh[13-SLOT_A4], sh[13-SLOT_A2], sh[13-SLOT_A1],
            sh[13-SLOT_B4], sh[13-SLOT_B2], sh[13-SLOT_B1],
            sh[13-SLOT_C4], sh[13-SLOT_C2], sh[13-SLOT_C1],
            sh[13-SLOT_D4], sh[13-SLOT_D2], sh[13-SLOT_D1]};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q a true two-stage pipeline;
  // blocking ones would collapse both stages into a single flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ssr_reply_decoder.sv
// SSR Mode A reply decoder: F1 qualification, 14 free-running slot samples,
// F2 check, then drain until the reply video drops.
module ssr_reply_decoder
  import ssr_reply_decoder_pkg::*;
#(
  parameter int L    = SSR_L,
  parameter int BL   = SSR_BL,
  parameter int SAMP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [11:0] code,
  output logic        x_bit,
  output logic        valid,
  output logic        err,
  output logic        busy
);

  localparam int         PITCH    = L + BL;
  localparam logic [4:0] CNT_LAST = 5'(PITCH - 1);
  localparam logic [4:0] CNT_SAMP = 5'(SAMP);
  localparam logic [3:0] IDX_F2   = 4'(SLOT_F2 - 1);

  state_t      state;
  logic        rx_s;
  logic        rx_d;
  logic [4:0]  cnt;
  logic [3:0]  idx;
  logic [12:0] shreg;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rx_d  <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      code  <= '0;
      x_bit <= 1'b0;
      valid <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rx_d  <= rx_s;
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_s && !rx_d) begin
            state <= F1_CHK;
            cnt   <= 5'd1;
            idx   <= '0;
            shreg <= '0;
            busy  <= 1'b1;
          end
        end

        // cnt tracks the offset from the F1 leading edge while F1 must stay high
        F1_CHK: begin
          if (!rx_s) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_SAMP) begin
            state <= SLOT;
            cnt   <= 5'd1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        // Slots are sampled whenever the free-running pitch counter wraps to 0
        SLOT: begin
          cnt <= (cnt == CNT_LAST) ? 5'd0 : cnt + 5'd1;
          if (cnt == 5'd0) begin
            if (idx == IDX_F2) begin
              state <= DRAIN;
              if (rx_s) begin
                valid <= 1'b1;
                code  <= slots_to_code(shreg);
                x_bit <= shreg[13-SLOT_X];
              end else begin
                err <= 1'b1;
              end
            end else begin
              shreg <= {shreg[11:0], rx_s};
              idx   <= idx + 4'd1;
            end
          end
        end

        DRAIN: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssr_reply_decoder.sv
// Self-checking bench for ssr_reply_decoder: table of frames, a transponder
// burst, and hand-written glitch / reset / stuck-high sequences.
module tb_ssr_reply_decoder;

  localparam int PITCH = 29;
  localparam int L     = 9;
  // rx driven after posedge s -> rx_s edge E = s+2 -> pulse visible at E+411
  localparam int LAT   = 413;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [11:0] code;
  logic        x_bit;
  logic        valid;
  logic        err;
  logic        busy;

  ssr_reply_decoder dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .code  (code),
    .x_bit (x_bit),
    .valid (valid),
    .err   (err),
    .busy  (busy)
  );

  always #25 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          due;
    logic        is_valid;
    logic [11:0] code;
    logic        x;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [11:0] code;
    logic        x;
    logic        f2;
    logic        exp_valid;
    logic [11:0] exp_code;
    logic        exp_x;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [14:0] frame_bits(input logic [11:0] c, input logic x, input logic f2);
    logic [14:0] b;
    b[0]  = 1'b1;  b[1]  = c[3];  b[2]  = c[9];  b[3]  = c[4];
    b[4]  = c[10]; b[5]  = c[5];  b[6]  = c[11]; b[7]  = x;
    b[8]  = c[6];  b[9]  = c[0];  b[10] = c[7];  b[11] = c[1];
    b[12] = c[8];  b[13] = c[2];  b[14] = f2;
    return b;
  endfunction

  task automatic push_exp(input int start, input logic v, input logic [11:0] c, input logic x);
    exp_t e;
    e.due = start + LAT;
    e.is_valid = v;
    e.code = c;
    e.x = x;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  // Drives one reply; stop_at truncates it (used for the mid-frame reset).
  task automatic send_frame(input logic [11:0] c, input logic x, input logic f2,
                            input int stop_at, input logic push,
                            input logic ev, input logic [11:0] ec, input logic ex,
                            output int start);
    logic [14:0] b;
    b = frame_bits(c, x, f2);
    step();
    start = cyc;
    if (push) push_exp(start, ev, ec, ex);
    for (int t = 0; t < 14*PITCH + L && t < stop_at; t++) begin
      if (t > 0) step();
      rx = b[4'(t / PITCH)] && ((t % PITCH) < L);
    end
    step();
    rx = 1'b0;
  endtask

  task automatic run_frame(input logic [11:0] c, input logic x, input logic f2,
                           input logic ev, input logic [11:0] ec, input logic ex);
    int s;
    send_frame(c, x, f2, 100000, 1'b1, ev, ec, ex, s);
    repeat (10) step();
  endtask

  // Output monitor: every valid/err pulse must match the head of the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (valid === 1'b1 || err === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, valid, err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_exclusive", {31'd0, valid & err}, 32'd0);
        check("pulse_valid", {31'd0, valid}, {31'd0, e.is_valid});
        check("pulse_err", {31'd0, err}, {31'd0, !e.is_valid});
        check("pulse_cycle", cyc, e.due);
        check("pulse_code", {20'd0, code}, {20'd0, e.code});
        check("pulse_x_bit", {31'd0, x_bit}, {31'd0, e.x});
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      check("missing_pulse_cycle", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d, want < 40000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   s;

    vecs[0] = '{12'o2645, 1'b1, 1'b1, 1'b1, 12'o2645, 1'b1};
    vecs[1] = '{12'o7777, 1'b1, 1'b0, 1'b0, 12'o2645, 1'b1};
    vecs[2] = '{12'o0000, 1'b0, 1'b1, 1'b1, 12'o0000, 1'b0};
    vecs[3] = '{12'o1234, 1'b0, 1'b1, 1'b1, 12'o1234, 1'b0};
    vecs[4] = '{12'o7070, 1'b1, 1'b1, 1'b1, 12'o7070, 1'b1};
    vecs[5] = '{12'o0707, 1'b0, 1'b0, 1'b0, 12'o7070, 1'b1};

    rst = 1'b0;
    rx  = 1'b0;
    repeat (3) step();
    check("reset_code", {20'd0, code}, 32'd0);
    check("reset_x_bit", {31'd0, x_bit}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (5) step();

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].code, vecs[i].x, vecs[i].f2,
                vecs[i].exp_valid, vecs[i].exp_code, vecs[i].exp_x);

    // Full transponder burst
    for (int i = 0; i < 16; i++)
      run_frame(12'o2645, 1'b1, 1'b1, 1'b1, 12'o2645, 1'b1);

    // 3-clock glitch while idle, then a legal frame
    step();
    s  = cyc;
    rx = 1'b1;
    repeat (3) step();
    rx = 1'b0;
    wait_until(s + 5);
    check("glitch_busy_e3", {31'd0, busy}, 32'd1);
    wait_until(s + 6);
    check("glitch_busy_e4", {31'd0, busy}, 32'd0);
    repeat (10) step();
    check("glitch_no_busy_later", {31'd0, busy}, 32'd0);
    run_frame(12'o3456, 1'b0, 1'b1, 1'b1, 12'o3456, 1'b0);

    // Reset around slot 8, then a legal frame
    send_frame(12'o5123, 1'b1, 1'b1, 8*PITCH + 3, 1'b0, 1'b0, 12'o0, 1'b0, s);
    rst = 1'b0;
    repeat (3) step();
    check("midreset_code", {20'd0, code}, 32'd0);
    check("midreset_x_bit", {31'd0, x_bit}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (500) step();
    check("postreset_idle", {31'd0, busy}, 32'd0);
    run_frame(12'o5123, 1'b1, 1'b1, 1'b1, 12'o5123, 1'b1);

    // rx stuck high through F2 and beyond: one frame, DRAIN until it falls
    step();
    s  = cyc;
    push_exp(s, 1'b1, 12'o7777, 1'b1);
    rx = 1'b1;
    wait_until(s + 480);
    check("stuck_high_drain_busy", {31'd0, busy}, 32'd1);
    rx = 1'b0;
    wait_until(s + 510);
    check("stuck_high_released", {31'd0, busy}, 32'd0);
    repeat (450) step();
    check("stuck_high_no_restart", {31'd0, busy}, 32'd0);

    repeat (5) step();
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
